// File: rtl/vga_fb_arbiter.sv
// Framebuffer access scheduler: look-ahead display reads for the VGA scan, host writes
// queued and drained during blanking. Define FB_ARB_WR_STATS_EN to build the drop counter.
module vga_fb_arbiter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [9:0]        iCurrent_X,
    input  logic [9:0]        iCurrent_Y,
    output logic [DATA_W-1:0] oPixel,
    output logic [18:0]       oMEM_ADDR,
    output logic              oMEM_WE,
    output logic [DATA_W-1:0] oMEM_WDATA,
    input  logic [DATA_W-1:0] iMEM_RDATA,
    input  logic              iWR_VALID,
    output logic              oWR_READY,
    input  logic [9:0]        iWR_X,
    input  logic [9:0]        iWR_Y,
    input  logic [DATA_W-1:0] iWR_DATA,
    output logic [15:0]       oDROP_CNT
);

    localparam int         PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_WRITE} state_e;

    function automatic logic [19:0] succ(input logic [9:0] x, input logic [9:0] y);
        logic [9:0] nx, ny;
        if (x == H_LAST) begin
            nx = '0;
            ny = (y == V_LAST) ? '0 : y + 10'd1;
        end else begin
            nx = x + 10'd1;
            ny = y;
        end
        return {nx, ny};
    endfunction

    // 640 = 512 + 128, so the common geometry needs no multiplier.
    function automatic logic [18:0] fb_addr(input logic [9:0] x, input logic [9:0] y);
        if (H_ACTIVE == 640)
            return ({9'd0, y} << 9) + ({9'd0, y} << 7) + {9'd0, x};
        else
            return 19'(y * H_ACTIVE) + {9'd0, x};
    endfunction

    // ---------------- look-ahead position ----------------
    logic [9:0]  p1_x, p1_y, p2_x, p2_y;
    logic        p2_active;
    logic [18:0] p2_addr;

    assign {p1_x, p1_y} = succ(iCurrent_X, iCurrent_Y);
    assign {p2_x, p2_y} = succ(p1_x, p1_y);
    assign p2_active    = (p2_x < H_ACT) && (p2_y < V_ACT);
    assign p2_addr      = fb_addr(p2_x, p2_y);

    // ---------------- host write FIFO ----------------
    logic [18:0]       fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_idx, rd_idx;
    logic              fifo_empty, fifo_full;
    logic              live_q;
    logic              wr_in_range, wr_accept, push, pop;
    logic [18:0]       wr_addr;

    assign wr_idx      = wr_ptr_q[PTR_W-1:0];
    assign rd_idx      = rd_ptr_q[PTR_W-1:0];
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
    assign oWR_READY   = live_q && !fifo_full;

    assign wr_in_range = (iWR_X < H_ACT) && (iWR_Y < V_ACT);
    assign wr_accept   = iWR_VALID && oWR_READY;
    assign push        = wr_accept && wr_in_range;
    // The display owns every cycle whose look-ahead lands in the active area.
    assign pop         = !p2_active && !fifo_empty;
    assign wr_addr     = fb_addr(iWR_X, iWR_Y);

    assign wr_ptr_d = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            live_q   <= 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_addr_q[wr_idx] <= wr_addr;
            fifo_data_q[wr_idx] <= iWR_DATA;
        end
    end

    // ---------------- memory command FSM ----------------
    state_e state_q;
    logic   rd_flag_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_IDLE;
            oMEM_ADDR  <= '0;
            oMEM_WE    <= 1'b0;
            oMEM_WDATA <= '0;
        end else begin
            oMEM_WE <= 1'b0;
            if (p2_active) begin
                state_q   <= ST_SCAN;
                oMEM_ADDR <= p2_addr;
            end else if (!fifo_empty) begin
                state_q    <= ST_WRITE;
                oMEM_ADDR  <= fifo_addr_q[rd_idx];
                oMEM_WDATA <= fifo_data_q[rd_idx];
                oMEM_WE    <= 1'b1;
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

    // Read data returns one cycle after the read command is on the bus.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) rd_flag_q <= 1'b0;
        else         rd_flag_q <= (state_q == ST_SCAN);
    end

    assign oPixel = rd_flag_q ? iMEM_RDATA : '0;

    // ---------------- drop statistics ----------------
`ifdef FB_ARB_WR_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt_d = (wr_accept && !wr_in_range && drop_cnt_q != 16'hFFFF)
                      ? drop_cnt_q + 16'd1 : drop_cnt_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_cnt_d;
    end

    assign oDROP_CNT = drop_cnt_q;
`else
    assign oDROP_CNT = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: directed scan positions and host writes,
// expected memory writes / pixels queued by stimulus and consumed by a monitor.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
    localparam int DW = 20;
`ifdef FB_ARB_WR_STATS_EN
    localparam int EXP_DROP = 2;
`else
    localparam int EXP_DROP = 0;
`endif

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic [9:0]    cur_x = '0, cur_y = '0;
    logic [DW-1:0] oPixel, oMEM_WDATA, mem_rdata;
    logic [18:0]   oMEM_ADDR;
    logic          oMEM_WE, oWR_READY;
    logic          iWR_VALID = 1'b0;
    logic [9:0]    iWR_X = '0, iWR_Y = '0;
    logic [DW-1:0] iWR_DATA = '0;
    logic [15:0]   oDROP_CNT;

    int checks = 0, errors = 0;
    bit acc;

    always #5 iCLK = ~iCLK;

    vga_fb_arbiter #(.DATA_W(DW)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iCurrent_X(cur_x), .iCurrent_Y(cur_y),
        .oPixel(oPixel),
        .oMEM_ADDR(oMEM_ADDR), .oMEM_WE(oMEM_WE), .oMEM_WDATA(oMEM_WDATA),
        .iMEM_RDATA(mem_rdata),
        .iWR_VALID(iWR_VALID), .oWR_READY(oWR_READY),
        .iWR_X(iWR_X), .iWR_Y(iWR_Y), .iWR_DATA(iWR_DATA),
        .oDROP_CNT(oDROP_CNT)
    );

    // Synchronous single-port memory; unwritten words read back as addr+1.
    logic [DW-1:0] wmem [int];
    always @(posedge iCLK) begin
        mem_rdata <= wmem.exists(int'(oMEM_ADDR)) ? wmem[int'(oMEM_ADDR)]
                                                   : DW'(int'(oMEM_ADDR) + 1);
        if (oMEM_WE) wmem[int'(oMEM_ADDR)] = oMEM_WDATA;
    end

    typedef struct { int addr; int data; bit chk; int x; int y; } wr_t;
    typedef struct { int x; int y; int val; } px_t;
    wr_t wr_q[$];
    px_t px_q[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void nxt(input int x, input int y, output int nx, output int ny);
        if (x == 799) begin nx = 0; ny = (y == 524) ? 0 : y + 1; end
        else begin nx = x + 1; ny = y; end
    endfunction

    task automatic cyc();
        int nx, ny;
        acc = iWR_VALID && oWR_READY;
        @(posedge iCLK); #1;
        nxt(cur_x, cur_y, nx, ny);
        cur_x = 10'(nx); cur_y = 10'(ny);
    endtask

    task automatic set_pos(input int x, input int y);
        cur_x = 10'(x); cur_y = 10'(y);
    endtask

    task automatic run_to(input int x, input int y);
        int n = 0;
        while (!(cur_x == 10'(x) && cur_y == 10'(y)) && n < 1000) begin cyc(); n++; end
        chk("run_to position", int'(cur_x) * 1000 + int'(cur_y), x * 1000 + y);
    endtask

    task automatic expect_wr(input int x, input int y, input int d, input int ex, input int ey);
        wr_t w;
        w.addr = y * 640 + x; w.data = d; w.chk = 1'b1; w.x = ex; w.y = ey;
        wr_q.push_back(w);
    endtask

    task automatic expect_px(input int x, input int y, input int v);
        px_t p;
        p.x = x; p.y = y; p.val = v;
        px_q.push_back(p);
    endtask

    // ex < 0 means the write must be accepted but never reach memory.
    task automatic push(input int x, input int y, input int d, input int ex, input int ey);
        int n = 0;
        iWR_VALID = 1'b1; iWR_X = 10'(x); iWR_Y = 10'(y); iWR_DATA = DW'(d);
        do begin cyc(); n++; end while (!acc && n < 50);
        iWR_VALID = 1'b0;
        chk("push accepted", int'(acc), 1);
        if (acc && ex >= 0) expect_wr(x, y, d, ex, ey);
    endtask

    // Monitor: pixels at queued positions, every memory write against the scoreboard.
    px_t mp;
    wr_t mw;
    int  mnx, mny;
    always @(negedge iCLK) begin
        if (iRST_N) begin
            if (px_q.size() > 0 && px_q[0].x == int'(cur_x) && px_q[0].y == int'(cur_y)) begin
                mp = px_q.pop_front();
                chk($sformatf("pixel(%0d,%0d)", mp.x, mp.y), int'(oPixel), mp.val);
            end
            if (oMEM_WE === 1'b1) begin
                nxt(cur_x, cur_y, mnx, mny);
                chk("write slot is blanking", int'(mnx >= 640 || mny >= 480), 1);
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected write: addr %0d data %0d at (%0d,%0d), expected none",
                             oMEM_ADDR, oMEM_WDATA, cur_x, cur_y);
                end else begin
                    mw = wr_q.pop_front();
                    chk("write addr", int'(oMEM_ADDR), mw.addr);
                    chk("write data", int'(oMEM_WDATA), mw.data);
                    if (mw.chk) chk("write timing x*1000+y", int'(cur_x) * 1000 + int'(cur_y),
                                    mw.x * 1000 + mw.y);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int held;
        int n;
        // ---- reset state ----
        repeat (3) @(posedge iCLK);
        #1;
        chk("reset oMEM_ADDR", int'(oMEM_ADDR), 0);
        chk("reset oMEM_WE", int'(oMEM_WE), 0);
        chk("reset oMEM_WDATA", int'(oMEM_WDATA), 0);
        chk("reset oPixel", int'(oPixel), 0);
        chk("reset oWR_READY", int'(oWR_READY), 0);
        chk("reset oDROP_CNT", int'(oDROP_CNT), 0);
        iRST_N = 1'b1;
        cyc();
        chk("ready after release", int'(oWR_READY), 1);

        // ---- display reads, no host traffic ----
        set_pos(796, 524);
        expect_px(0, 0, 1);
        expect_px(5, 0, 6);
        run_to(10, 0);
        set_pos(630, 0);
        expect_px(639, 0, 640);
        expect_px(640, 0, 0);
        expect_px(641, 0, 0);
        run_to(645, 0);
        set_pos(630, 479);
        expect_px(639, 479, 307200);
        expect_px(640, 479, 0);
        run_to(645, 479);
        set_pos(796, 479);
        expect_px(0, 480, 0);
        expect_px(3, 480, 0);
        run_to(5, 480);

        // ---- four writes to (10,5) pushed mid-line, drained from (639,5) ----
        set_pos(95, 5);
        run_to(100, 5);
        for (int i = 0; i < 4; i++) push(10, 5, 'hA1 + i, 639 + i, 5);
        run_to(700, 5);

        // ---- fill FIFO, hold the 17th until the first pop ----
        set_pos(0, 10);
        for (int i = 0; i < 16; i++) push(20 + i, 10, 'h100 + i, 639 + i, 10);
        chk("ready low when full", int'(oWR_READY), 0);
        iWR_VALID = 1'b1; iWR_X = 10'd50; iWR_Y = 10'd10; iWR_DATA = DW'('h1FF);
        held = 0; n = 0;
        while (!(cur_x == 10'd638 && cur_y == 10'd10) && n < 1000) begin
            cyc(); n++;
            if (acc) held = 1;
        end
        chk("17th held while full", held, 0);
        chk("ready low before first pop", int'(oWR_READY), 0);
        cyc();
        chk("ready high after first pop", int'(oWR_READY), 1);
        cyc();
        chk("17th accepted", int'(acc), 1);
        iWR_VALID = 1'b0;
        expect_wr(50, 10, 'h1FF, 655, 10);
        run_to(700, 10);

        // ---- out-of-range writes are accepted and dropped ----
        set_pos(0, 20);
        push(640, 0, 'h55, -1, 0);
        push(0, 480, 'h66, -1, 0);
        run_to(700, 20);
        chk("drop count", int'(oDROP_CNT), EXP_DROP);

        // ---- reset during a WRITE with 7 entries left ----
        set_pos(0, 30);
        for (int i = 0; i < 10; i++) push(100 + i, 30, 'h300 + i, (i < 2) ? 639 + i : -1, 30);
        run_to(641, 30);
        chk("write in flight before reset", int'(oMEM_WE), 1);
        iRST_N = 1'b0;
        #1;
        chk("WE cleared by reset", int'(oMEM_WE), 0);
        chk("pixel cleared by reset", int'(oPixel), 0);
        chk("ready low in reset", int'(oWR_READY), 0);
        cyc();
        cyc();
        iRST_N = 1'b1;
        cyc();
        chk("ready after second release", int'(oWR_READY), 1);
        chk("drop count cleared", int'(oDROP_CNT), 0);
        set_pos(600, 30);
        run_to(700, 31);

        chk("writes outstanding", wr_q.size(), 0);
        chk("pixels outstanding", px_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
